// File: rtl/result_collector.sv
// rtl/result_collector.sv - tags finished systolic tiles with their C position and streams them to the result RAM
// Tiles are buffered in a small FIFO plus a registered write stage; occupancy counts both.
module result_collector #(
  parameter int WIDTH          = 16,
  parameter int CHUNK_SIZE     = 4,
  parameter int ROW_SIZE_MAT_C = 5,
  parameter int COL_SIZE_MAT_C = 3,
  parameter int FIFO_DEPTH     = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int COL_MAJOR      = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [WIDTH*CHUNK_SIZE-1:0]   in_data,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [WIDTH*CHUNK_SIZE-1:0]   wr_data,
  input  logic                          wr_ack,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic [ADDR_WIDTH-1:0]         tile_count
);

  localparam int DW    = WIDTH * CHUNK_SIZE;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int MAX   = ROW_SIZE_MAT_C * COL_SIZE_MAT_C;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

  state_t state, next_state;

  logic                  prev_valid;
  logic [ADDR_WIDTH-1:0] row_q, col_q, cap_addr;
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      fifo_cnt, occ;
  logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic [DW-1:0]         mem_data [FIFO_DEPTH];

  logic capture, pop, full, in_collect, push, drop, load, clear, last_tile;

  always_comb begin
    capture    = in_valid & ~prev_valid;
    pop        = wr_en & wr_ack;
    occ        = fifo_cnt + CNT_W'(wr_en);
    full       = (occ == CNT_W'(FIFO_DEPTH));
    in_collect = (state == S_COLLECT);
    push       = capture & in_collect & (~full | pop);
    drop       = capture & ((in_collect & full & ~pop) | (state == S_DRAIN));
    // The write stage refills from the FIFO whenever it is empty or being acknowledged.
    load       = (~wr_en | pop) & (fifo_cnt != '0);
    clear      = start & ((state == S_IDLE) | (state == S_DONE));
    last_tile  = (tile_count == ADDR_WIDTH'(MAX - 1));
    busy       = (state == S_COLLECT) | (state == S_DRAIN);
    done       = (state == S_DONE);
  end

  always_comb begin
    if (COL_MAJOR != 0)
      cap_addr = col_q * ADDR_WIDTH'(ROW_SIZE_MAT_C) + row_q;
    else
      cap_addr = row_q * ADDR_WIDTH'(COL_SIZE_MAT_C) + col_q;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start) next_state = S_COLLECT;
      S_COLLECT: if (capture && last_tile) next_state = S_DRAIN;
      S_DRAIN:   if (fifo_cnt == '0 && (!wr_en || pop)) next_state = S_DONE;
      S_DONE:    if (start) next_state = S_COLLECT;
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= cap_addr;
      mem_data[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      tile_count <= '0;
      overflow   <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_cnt   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      prev_valid <= in_valid;
      if (clear) begin
        row_q      <= '0;
        col_q      <= '0;
        tile_count <= '0;
        overflow   <= 1'b0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        fifo_cnt   <= '0;
        wr_en      <= 1'b0;
      end else begin
        // Dropped tiles still advance the position so later addresses stay correct.
        if (capture && in_collect) begin
          tile_count <= tile_count + ADDR_WIDTH'(1);
          if (col_q == ADDR_WIDTH'(COL_SIZE_MAT_C - 1)) begin
            col_q <= '0;
            row_q <= row_q + ADDR_WIDTH'(1);
          end else begin
            col_q <= col_q + ADDR_WIDTH'(1);
          end
        end
        if (drop) overflow <= 1'b1;
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (load) begin
          wr_en   <= 1'b1;
          wr_addr <= mem_addr[rd_ptr];
          wr_data <= mem_data[rd_ptr];
          rd_ptr  <= rd_ptr + PTR_W'(1);
        end else if (pop) begin
          wr_en <= 1'b0;
        end
        fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(load);
      end
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - scoreboard bench for result_collector, row- and column-major instances
module tb_result_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        wr_ack = 1'b1;

  logic        wr_en, busy, done, overflow;
  logic [15:0] wr_addr, tile_count;
  logic [63:0] wr_data;
  logic        cm_wr_en, cm_busy, cm_done, cm_overflow;
  logic [15:0] cm_wr_addr, cm_tile_count;
  logic [63:0] cm_wr_data;

  typedef struct packed {
    logic [15:0] k;
    logic [63:0] d;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   phase = 0;
  int   cm_tab[15] = '{0, 5, 10, 1, 6, 11, 2, 7, 12, 3, 8, 13, 4, 9, 14};

  always #5 clk = ~clk;

  result_collector #(.COL_MAJOR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .busy(busy), .done(done), .overflow(overflow), .tile_count(tile_count)
  );

  result_collector #(.COL_MAJOR(1)) dut_cm (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .wr_en(cm_wr_en), .wr_addr(cm_wr_addr), .wr_data(cm_wr_data), .wr_ack(wr_ack),
    .busy(cm_busy), .done(cm_done), .overflow(cm_overflow), .tile_count(cm_tile_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int k);
    return {16'hA5C3, 16'(phase), 16'(k), 16'(k * 7 + 1)};
  endfunction

  always @(negedge clk) begin
    if (!rst && wr_en && wr_ack) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rm_extra_write actual_addr=%0h expected=none", wr_addr);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("rm_addr", 64'(wr_addr), 64'(e.k));
        chk("rm_data", wr_data, e.d);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && cm_wr_en && wr_ack) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cm_extra_write actual_addr=%0h expected=none", cm_wr_addr);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("cm_addr", 64'(cm_wr_addr), 64'(cm_tab[e.k]));
        chk("cm_data", cm_wr_data, e.d);
      end
    end
  end

  task automatic tile(input int k, input int hi, input int gap, input bit exp_push);
    exp_t e;
    e.k = 16'(k);
    e.d = mk(k);
    if (exp_push) begin
      q0.push_back(e);
      q1.push_back(e);
    end
    in_data  = e.d;
    in_valid = 1'b1;
    repeat (hi) @(posedge clk);
    #1 in_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 64'(q0.size() + q1.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_tile_count", 64'(tile_count), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 15 pulses, both address orders
    phase = 1;
    do_start();
    for (int k = 0; k < 14; k++) begin
      tile(k, 1, 3, 1'b1);
      chk("t1_tile_count", 64'(tile_count), 64'(k + 1));
    end
    tile(14, 1, 0, 1'b1);
    chk("t1_count_15", 64'(tile_count), 64'd15);
    chk("t1_drain_busy", 64'(busy), 64'd1);
    chk("t1_wr_en_latency", 64'(wr_en), 64'd0);
    @(posedge clk);
    #1;
    chk("t1_wr_en_up", 64'(wr_en), 64'd1);
    chk("t1_not_done_yet", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_busy_low", 64'(busy), 64'd0);
    chk("t1_cm_done", 64'(cm_done), 64'd1);
    chk("t1_overflow", 64'(overflow), 64'd0);
    chk("t1_queue_empty", 64'(q0.size() + q1.size()), 64'd0);
    tile(15, 1, 2, 1'b0);
    chk("done_ignore_count", 64'(tile_count), 64'd15);
    chk("done_ignore_ovf", 64'(overflow), 64'd0);
    chk("done_held", 64'(done), 64'd1);

    // in_valid held high six cycles per tile
    phase = 2;
    do_start();
    chk("t2_count_cleared", 64'(tile_count), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tile(k, 6, 2, 1'b1);
      chk("t2_one_capture", 64'(tile_count), 64'(k + 1));
    end
    wait_drain("t2_drain");
    do_rst();

    // backpressure overflow
    phase = 3;
    do_start();
    wr_ack = 1'b0;
    for (int k = 0; k < 6; k++) tile(k, 1, 3, k < 4);
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_count", 64'(tile_count), 64'd6);
    chk("t3_hold_en", 64'(wr_en), 64'd1);
    chk("t3_hold_addr", 64'(wr_addr), 64'd0);
    wr_ack = 1'b1;
    wait_drain("t3_drain");
    tile(6, 1, 3, 1'b1);
    chk("t3_queue_after_6", 64'(q0.size()), 64'd0);

    // reset with a write outstanding
    wr_ack = 1'b0;
    tile(7, 1, 2, 1'b1);
    chk("t4_pending_en", 64'(wr_en), 64'd1);
    chk("t4_pending_addr", 64'(wr_addr), 64'd7);
    do_rst();
    chk("t4_rst_wr_en", 64'(wr_en), 64'd0);
    chk("t4_rst_addr", 64'(wr_addr), 64'd0);
    chk("t4_rst_data", wr_data, 64'd0);
    chk("t4_rst_busy", 64'(busy), 64'd0);
    chk("t4_rst_ovf", 64'(overflow), 64'd0);
    chk("t4_rst_count", 64'(tile_count), 64'd0);

    // restart from addr 0, then a capture during DRAIN
    phase = 5;
    wr_ack = 1'b1;
    do_start();
    for (int k = 0; k < 14; k++) tile(k, 1, 3, 1'b1);
    tile(14, 1, 1, 1'b1);
    wr_ack = 1'b0;
    tile(15, 1, 1, 1'b0);
    chk("drain_ignore_count", 64'(tile_count), 64'd15);
    chk("drain_overflow", 64'(overflow), 64'd1);
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_not_done", 64'(done), 64'd0);
    wr_ack = 1'b1;
    wait_drain("t5_drain");
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_overflow_kept", 64'(overflow), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_collector.md
# result_collector

Hardware write-back end of the multi-MAC matrix-multiply datapath. It captures each finished systolic output tile, one `WIDTH*CHUNK_SIZE` word per `accumulator_done` rising edge, and tags it with its (row, col) position in matrix C. Tiles are buffered in a small FIFO and written into the result RAM through a write/ack handshake. It counts tiles up to `ROW_SIZE_MAT_C*COL_SIZE_MAT_C` and flags completion.

## Interface
- `WIDTH`, 16: fixed-point element width.
- `CHUNK_SIZE`, 4: elements per tile word (BLOCK_SIZE²).
- `ROW_SIZE_MAT_C`, 5: tile rows of C (ROW_SIZE_MAT_A/BLOCK_SIZE).
- `COL_SIZE_MAT_C`, 3: tile cols of C (COL_SIZE_MAT_B/BLOCK_SIZE).
- `FIFO_DEPTH`, 4: buffered tiles; power of two, ≥2.
- `ADDR_WIDTH`, 16: result RAM address width.
- `COL_MAJOR`, 0: 0 → addr = row*COL_SIZE_MAT_C+col; 1 → addr = col*ROW_SIZE_MAT_C+row.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  arm a new matrix; honored only in IDLE or DONE.
- `in_valid`  in  1  accumulator_done level from toplevel; capture on its rising edge.
- `in_data`  in  WIDTH*CHUNK_SIZE  tile word (toplevel `out`).
- `wr_en`  out  1  write request to result RAM.
- `wr_addr`  out  ADDR_WIDTH  tile address.
- `wr_data`  out  WIDTH*CHUNK_SIZE  tile word.
- `wr_ack`  in  1  RAM accepts the current write this cycle.
- `busy`  out  1  state is COLLECT or DRAIN.
- `done`  out  1  all MAX tiles written; held until start or rst.
- `overflow`  out  1  sticky: a capture was dropped.
- `tile_count`  out  ADDR_WIDTH  tiles captured since start.

## Operation
- MAX = ROW_SIZE_MAT_C*COL_SIZE_MAT_C.
- Edge detect: capture when `in_valid`=1 and registered previous value = 0; the previous-value register resets to 0. A level held high yields exactly one capture.
- Position counters: col increments per capture; at COL_SIZE_MAT_C-1 it wraps to 0 and row increments. Address is computed at capture and stored in the FIFO with the data.
- FSM:
  - IDLE: outputs quiet. `start` clears counters, FIFO, overflow → COLLECT.
  - COLLECT: captures pushed. On the capture making tile_count = MAX → DRAIN.
  - DRAIN: captures ignored and set overflow. FIFO empty and no pending write → DONE.
  - DONE: `done`=1. `start` re-arms (same clearing) → COLLECT.
- Captures in IDLE or DONE are ignored. They do not set overflow.
- Push accepted if FIFO count < FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the tile is dropped, overflow is set, and counters still advance so later addresses stay correct.
- Write side: when FIFO is non-empty, present head on `wr_addr`/`wr_data` with `wr_en`=1. Hold all three stable until the `wr_ack` cycle, then pop. `wr_ack` with `wr_en`=0 is ignored.
- `start` in COLLECT or DRAIN is ignored.

## Timing
- Reset values: wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, overflow 0, tile_count 0, state IDLE, FIFO empty.
- `rst` mid-operation: next edge forces reset values; an outstanding write is abandoned (wr_en drops without ack).
- `start` sampled at edge E: busy=1 from E.
- Capture at edge N: tile_count updates at N. The entry is visible on wr_en/wr_addr/wr_data after edge N+1 if the FIFO was empty (1-cycle latency).
- With `wr_ack` tied high, throughput is one write per cycle. wr_en stays high across back-to-back entries.
- DRAIN→DONE: at the edge where the last ack pops the final entry. done=1 and busy=0 after that edge.

## Test plan
- Defaults, 15 single-cycle `in_valid` pulses 4 cycles apart, wr_ack=1 → 15 writes, addrs 0..14 in order, data matches. done=1 one cycle after the 15th ack. overflow=0.
- `COL_MAJOR`=1, same stimulus → write sequence 0,5,10,1,6,11,2,7,12,…,14.
- `in_valid` held high 6 cycles per tile → exactly one capture per high period. tile_count increments by 1 each.
- wr_ack=0 while 6 tiles arrive → first 4 buffered, tiles 5–6 dropped, overflow=1. Release ack → addrs 0,1,2,3 written; later tiles continue at addr 6.
- `rst` pulse after tile 7 with wr_en high → all outputs 0 next cycle. A new `start` restarts at addr 0.
- 16th capture after tile_count=15 (in DRAIN) → ignored, overflow=1. In DONE → ignored, overflow unchanged.
